serial_mod3_transmitter: RTL and testbench
==========================================

Name: serial_mod3_transmitter

Overview:
- MSB-first parallel-to-serial transmitter. Produces the one-bit-per-clock stream consumed by the multiple-of-three detector FSM.
- Tracks the running residue mod 3 of the emitted prefix. Its mult3 output is the golden expected value for the detector's `out`, for checking in system and bench.
- Sits between a word source (valid/ready handshake) and the serial detector input.

Parameters:
- WIDTH, 8, bits per word serialised; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  source presents a word on load_data.
- load_data  input  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- load_ready  output  1  transmitter accepts a word this cycle.
- out  output  1  current serial bit; drives detector `in`.
- out_valid  output  1  out carries a data bit this cycle.
- last  output  1  current bit is the final bit of the word.
- residue  output  2  (prefix value including current bit) mod 3; range 0..2.
- mult3  output  1  residue == 0 while out_valid; 0 otherwise.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; shift register, bit counter and residue_q clear.
  - Outputs: out=0, out_valid=0, last=0, residue=0, mult3=0, load_ready=1 (once reset has released).
- State IDLE:
  - load_ready=1, out_valid=0.
  - Accept = load_valid & load_ready at a rising edge. On accept: latch load_data into shreg, set cnt=WIDTH-1, set residue_q=0, go to SHIFT.
- State SHIFT:
  - out=shreg[WIDTH-1], out_valid=1, last=(cnt==0).
  - Each edge: shreg shifts left one place (zero fill), cnt decrements, residue_q <= (2*residue_q + out) mod 3.
- Residue arithmetic:
  - residue = (2*residue_q + out) mod 3, combinational from registered state.
  - Computed with 2-bit logic only; no WIDTH-bit divider.
- Latency: first bit appears on out in the cycle after accept. The word occupies exactly WIDTH consecutive out_valid cycles.
- Back-to-back transfers:
  - load_ready = IDLE | (SHIFT & last).
  - An accept on the last-bit cycle reloads shreg, cnt and residue_q, so the next word's MSB follows with no gap.
  - If there is no accept on the last-bit cycle, return to IDLE.
- load_valid while SHIFT and not last: ignored. load_data is not sampled; the word in flight is unaffected.
- load_data changing after accept: no effect.
- Reset mid-word: transmission aborts immediately. The partial word is discarded; there is no resume after release.
- X on load_data while load_valid=0: must not propagate to any output.

Optional Feature:
- Macro: LSB_FIRST_EN.
- Defined:
  - Bit 0 is sent first; shreg shifts right.
  - Residue is tracked with a position-parity flag p (cleared on accept, toggles each bit). Update: residue_q <= (residue_q + (p ? 2 : 1)*out) mod 3, since bit weights 2^k alternate 1,2 mod 3.
  - residue/mult3 report the residue of the bits sent so far at their true weights. At last they equal the full word mod 3.
- Undefined: MSB-first behaviour above; no p register is synthesised.

Test Plan:
- Reset then idle: hold reset=0 40 ns, release, load_valid=0 -> out_valid=0, mult3=0, load_ready=1 for 10 cycles.
- Single word, WIDTH=8, load_data=8'h6D (0110_1101) -> out sequence 0,1,1,0,1,1,0,1; residue 0,1,0,0,1,0,0,1; mult3 1,0,1,1,0,1,1,0; last only on 8th bit; load_ready=0 on bits 1-7.
- Back-to-back: 8'h6D, then 8'hFF held valid and accepted on last cycle -> 16 consecutive out_valid cycles. Second word residue restarts: 1,0,1,0,1,0,1,0; final mult3=1 (255 mod 3=0).
- Busy-ignore: during bit 3 of 8'h6D pulse load_valid with 8'h00 -> stream unchanged; 8'h00 is not transmitted; IDLE after bit 8.
- Reset mid-word: assert reset low during bit 4 of 8'h6D -> out_valid, mult3, residue drop to 0 within the same cycle (asynchronous). After release, load 8'h03 -> stream 0,0,0,0,0,0,1,1 with final mult3=1.
- LSB_FIRST_EN build, load_data=8'h6D -> out 1,0,1,1,0,1,1,0; residue at last=1 (109 mod 3); mult3 at last=0.

Source files
------------

// File: rtl/serial_mod3_transmitter.sv
// MSB-first parallel-to-serial transmitter that also reports the running residue mod 3 of the emitted prefix.
// Optional macro LSB_FIRST_EN: send bit 0 first and track residue with alternating bit weights.
module serial_mod3_transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic [1:0]       residue,
    output logic             mult3
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    cnt_reg;
    logic [1:0]       res_reg;

    logic       shifting;
    logic       cur_bit;
    logic       accept;
    logic [1:0] res_next;

`ifdef LSB_FIRST_EN
    logic p_reg;

    // Bit weights 2^k are 1,2,1,2... mod 3, so p selects adding 1 or 2.
    function automatic logic [1:0] res_step(input logic [1:0] r, input logic p, input logic b);
        logic [1:0] s;
        s = r;
        if (b) begin
            case (r)
                2'd0:    s = p ? 2'd2 : 2'd1;
                2'd1:    s = p ? 2'd0 : 2'd2;
                default: s = p ? 2'd1 : 2'd0;
            endcase
        end
        return s;
    endfunction

    assign cur_bit  = shreg_reg[0];
    assign res_next = res_step(res_reg, p_reg, out);
`else
    // (2*r + b) mod 3 as a 2-bit lookup.
    function automatic logic [1:0] res_step(input logic [1:0] r, input logic b);
        logic [1:0] s;
        s = 2'd0;
        case ({r, b})
            3'b000:  s = 2'd0;
            3'b001:  s = 2'd1;
            3'b010:  s = 2'd2;
            3'b011:  s = 2'd0;
            3'b100:  s = 2'd1;
            3'b101:  s = 2'd2;
            default: s = 2'd0;
        endcase
        return s;
    endfunction

    assign cur_bit  = shreg_reg[WIDTH-1];
    assign res_next = res_step(res_reg, out);
`endif

    assign shifting   = (state_reg == SHIFT);
    assign out        = shifting & cur_bit;
    assign out_valid  = shifting;
    assign last       = shifting && (cnt_reg == '0);
    assign load_ready = !shifting || last;
    assign accept     = load_valid && load_ready;
    assign residue    = res_next;
    assign mult3      = shifting && (res_next == 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            res_reg   <= 2'd0;
`ifdef LSB_FIRST_EN
            p_reg     <= 1'b0;
`endif
        end else if (accept) begin
            // Covers both an idle load and a gapless reload on the last bit.
            state_reg <= SHIFT;
            shreg_reg <= load_data;
            cnt_reg   <= CW'(WIDTH - 1);
            res_reg   <= 2'd0;
`ifdef LSB_FIRST_EN
            p_reg     <= 1'b0;
`endif
        end else if (shifting) begin
            if (last) begin
                state_reg <= IDLE;
                shreg_reg <= '0;
                res_reg   <= 2'd0;
`ifdef LSB_FIRST_EN
                p_reg     <= 1'b0;
`endif
            end else begin
`ifdef LSB_FIRST_EN
                shreg_reg <= {1'b0, shreg_reg[WIDTH-1:1]};
                p_reg     <= ~p_reg;
`else
                shreg_reg <= {shreg_reg[WIDTH-2:0], 1'b0};
`endif
                cnt_reg   <= cnt_reg - CW'(1);
                res_reg   <= res_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_mod3_transmitter.sv
// Self-checking bench for serial_mod3_transmitter: directed vector table, reset sequences, random traffic vs a queue model.
module tb_serial_mod3_transmitter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         out;
    logic         out_valid;
    logic         last;
    logic [1:0]   residue;
    logic         mult3;

    int n_vec = 0;
    int n_err = 0;

    serial_mod3_transmitter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .last       (last),
        .residue    (residue),
        .mult3      (mult3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         ov;
        logic         o;
        logic         l;
        logic [1:0]   r;
        logic         m;
        logic         rdy;
    } vec_t;

    typedef struct {
        logic       b;
        logic       l;
        logic [1:0] r;
    } exp_bit_t;

    vec_t     tbl[$];
    exp_bit_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [W-1:0] d, input logic ov, input logic o,
                       input logic l, input logic [1:0] r, input logic m, input logic rdy);
        vec_t t;
        t.v = v; t.d = d; t.ov = ov; t.o = o; t.l = l; t.r = r; t.m = m; t.rdy = rdy;
        tbl.push_back(t);
    endtask

    task automatic drive_and_check(input vec_t t, input string tag);
        @(negedge clk);
        load_valid = t.v;
        load_data  = t.d;
        #1;
        chk({tag, ".out_valid"},  out_valid,  t.ov);
        chk({tag, ".out"},        out,        t.o);
        chk({tag, ".last"},       last,       t.l);
        chk({tag, ".residue"},    residue,    t.r);
        chk({tag, ".mult3"},      mult3,      t.m);
        chk({tag, ".load_ready"}, load_ready, t.rdy);
        if (t.v && load_ready) $display("tx %s: word %h accepted", tag, t.d);
    endtask

    // Reference: an accepted word becomes W queued bits, each tagged with its prefix value mod 3.
    task automatic model_push(input logic [W-1:0] d);
        exp_bit_t e;
        longint   pv;
        for (int i = 0; i < W; i++) begin
`ifdef LSB_FIRST_EN
            e.b = d[i];
            pv  = longint'(d) & ((longint'(1) << (i + 1)) - 1);
`else
            e.b = d[W-1-i];
            pv  = longint'(d) >> (W - 1 - i);
`endif
            e.r = 2'(pv % 3);
            e.l = (i == W - 1);
            mq.push_back(e);
        end
    endtask

    logic [W-1:0] dx;
    logic [W-1:0] o_exp;
    logic [1:0]   r_exp[W];
    logic [W-1:0] s03;
    vec_t         t;

    initial begin
        dx         = 'x;
        load_valid = 1'b0;
        load_data  = '0;
        reset      = 1'b0;

        // Reset state while held
        #20;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out",       out,       1'b0);
        chk("rst.last",      last,      1'b0);
        chk("rst.residue",   residue,   2'd0);
        chk("rst.mult3",     mult3,     1'b0);
        #20;
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_data  = dx;
            #1;
            chk("idle.out_valid",  out_valid,  1'b0);
            chk("idle.mult3",      mult3,      1'b0);
            chk("idle.load_ready", load_ready, 1'b1);
        end

        // Directed table, expected bit order for 8'h6D
`ifdef LSB_FIRST_EN
        o_exp = 8'b10110110;
        r_exp = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
`else
        o_exp = 8'b01101101;
        r_exp = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
`endif
        add(1'b1, 8'h6D, 0, 0, 0, 2'd0, 0, 1);
        for (int i = 0; i < W; i++) begin
`ifdef LSB_FIRST_EN
            add(1'b0, dx, 1, o_exp[W-1-i], i == W-1, r_exp[i], r_exp[i] == 2'd0, i == W-1);
`else
            // Back-to-back: offer 8'hFF only on the last bit of the first word
            add(i == W-1, (i == W-1) ? 8'hFF : dx, 1, o_exp[W-1-i], i == W-1,
                r_exp[i], r_exp[i] == 2'd0, i == W-1);
`endif
        end
`ifndef LSB_FIRST_EN
        for (int i = 1; i <= W; i++)
            add(1'b0, dx, 1, 1, i == W, 2'(i % 2), (i % 2) == 0, i == W);
`endif
        add(1'b0, dx, 0, 0, 0, 2'd0, 0, 1);
`ifndef LSB_FIRST_EN
        // Busy-ignore: 8'h00 pulsed during bit 3 must not disturb the stream
        add(1'b1, 8'h6D, 0, 0, 0, 2'd0, 0, 1);
        for (int i = 0; i < W; i++)
            add(i == 2, (i == 2) ? 8'h00 : dx, 1, o_exp[W-1-i], i == W-1,
                r_exp[i], r_exp[i] == 2'd0, i == W-1);
        add(1'b0, dx, 0, 0, 0, 2'd0, 0, 1);
        add(1'b0, dx, 0, 0, 0, 2'd0, 0, 1);
`endif
        foreach (tbl[k]) drive_and_check(tbl[k], $sformatf("tbl%0d", k));

        // Reset in the middle of bit 4 of 8'h6D
        t = '{v: 1'b1, d: 8'h6D, ov: 0, o: 0, l: 0, r: 2'd0, m: 0, rdy: 1};
        drive_and_check(t, "mid.load");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_data  = dx;
        end
        @(negedge clk);
        #1;
        chk("mid.bit4_valid", out_valid, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid.out_valid", out_valid, 1'b0);
        chk("mid.mult3",     mult3,     1'b0);
        chk("mid.residue",   residue,   2'd0);
        chk("mid.out",       out,       1'b0);
        @(negedge clk);
        reset = 1'b1;
        t = '{v: 1'b0, d: dx, ov: 0, o: 0, l: 0, r: 2'd0, m: 0, rdy: 1};
        drive_and_check(t, "mid.idle");

`ifdef LSB_FIRST_EN
        s03 = 8'b11000000;
`else
        s03 = 8'b00000011;
`endif
        t = '{v: 1'b1, d: 8'h03, ov: 0, o: 0, l: 0, r: 2'd0, m: 0, rdy: 1};
        drive_and_check(t, "rel.load");
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            load_data  = dx;
            #1;
            chk($sformatf("rel.bit%0d.out", i),       out,       s03[W-1-i]);
            chk($sformatf("rel.bit%0d.out_valid", i), out_valid, 1'b1);
        end
        chk("rel.last",  last,  1'b1);
        chk("rel.mult3", mult3, 1'b1);
        @(negedge clk);
        #1;
        chk("rel.done_valid", out_valid, 1'b0);

        // Random traffic against the queue model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            logic       v, e_ov, e_o, e_l, e_m, e_rdy, acc;
            logic [1:0] e_r;
            @(negedge clk);
            v          = ($urandom_range(0, 9) < 6);
            load_valid = v;
            load_data  = v ? W'($urandom) : dx;
            #1;
            e_ov  = (mq.size() > 0);
            e_o   = e_ov ? mq[0].b : 1'b0;
            e_l   = e_ov ? mq[0].l : 1'b0;
            e_r   = e_ov ? mq[0].r : 2'd0;
            e_m   = e_ov && (e_r == 2'd0);
            e_rdy = (mq.size() <= 1);
            chk("rnd.out_valid",  out_valid,  e_ov);
            chk("rnd.out",        out,        e_o);
            chk("rnd.last",       last,       e_l);
            chk("rnd.residue",    residue,    e_r);
            chk("rnd.mult3",      mult3,      e_m);
            chk("rnd.load_ready", load_ready, e_rdy);
            acc = v && e_rdy;
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                model_push(load_data);
                $display("tx rnd%0d: word %h accepted", c, load_data);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
